sprite_plotter: RTL and testbench

Pixel-drawing responder for the game view state machine: accepts a level-held draw request (gold, stone, hook or erase) with a base coordinate and returns a one-cycle `done` after rasterising a fixed-size sprite into the VGA frame buffer write port. Sits between the view FSM's `enable_draw_*` outputs and the VGA adapter's `x`/`y`/`colour`/`plot` inputs. The FSM holds its enable high until `done` is asserted.

---
 rtl/sprite_plotter.sv | 210 +++++++++++++++++++++
 tb/tb_sprite_plotter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// sprite_plotter: rasterises a fixed-size sprite (gold, stone, hook or erase)
// into the VGA frame buffer write port, one pixel per cycle, in response to a
// level-held draw request. Answers with a one-cycle done pulse.
//
// Build option: define PLOTTER_CLIP_EN to suppress plot strobes for pixels
// whose untruncated coordinates fall outside SCREEN_W x SCREEN_H. Without it,
// coordinates wrap to the port width and every unmasked pixel is plotted.
//
// Pipeline: counter stage -> pixel stage -> output registers, so the pixel
// for DRAW cycle k reaches the ports two edges after that cycle starts, and
// done travels down the same pipe to stay aligned with the last pixel.

module sprite_plotter #(
  parameter int unsigned SPRITE_W = 8,
  parameter int unsigned SPRITE_H = 8,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] obj_type,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(SPRITE_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(SPRITE_H - 1);

`ifdef PLOTTER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [2:0] COL_GOLD  = 3'b110;
  localparam logic [2:0] COL_STONE = 3'b111;
  localparam logic [2:0] COL_HOOK  = 3'b000;
  localparam logic [2:0] COL_ERASE = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAW    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [1:0]     obj_q;
  logic [7:0]     bx_q;
  logic [6:0]     by_q;
  logic [CXW-1:0] cx_q;
  logic [CYW-1:0] cy_q;

  logic           accept_c;
  logic           draw_c;
  logic           last_c;
  logic           fin_c;

  logic [8:0]     x_wide_c;
  logic [7:0]     y_wide_c;
  logic           on_screen_c;
  logic           corner_c;
  logic           masked_c;
  logic           pix_plot_c;
  logic [2:0]     pix_colour_c;

  logic           p_valid_q;
  logic           p_plot_q;
  logic           p_done_q;
  logic [7:0]     p_x_q;
  logic [6:0]     p_y_q;
  logic [2:0]     p_colour_q;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept_c) state_d = S_DRAW;
      S_DRAW:    if (last_c)   state_d = S_DONE;
      S_DONE:    state_d = enable ? S_RELEASE : S_IDLE;
      S_RELEASE: if (!enable)  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM control decode; a new accept waits until the previous done has left the pipe
  always_comb begin
    accept_c = 1'b0;
    draw_c   = 1'b0;
    last_c   = 1'b0;
    fin_c    = 1'b0;
    case (state_q)
      S_IDLE:  accept_c = enable && (!busy || done);
      S_DRAW: begin
        draw_c = 1'b1;
        last_c = (cx_q == CX_LAST) && (cy_q == CY_LAST);
      end
      S_DONE:  fin_c = 1'b1;
      default: ;
    endcase
  end

  // Request latch and raster counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      obj_q <= 2'd0;
      bx_q  <= 8'd0;
      by_q  <= 7'd0;
      cx_q  <= '0;
      cy_q  <= '0;
    end else if (accept_c) begin
      obj_q <= obj_type;
      bx_q  <= base_x;
      by_q  <= base_y;
      cx_q  <= '0;
      cy_q  <= '0;
    end else if (draw_c) begin
      if (last_c) begin
        cx_q <= '0;
        cy_q <= '0;
      end else if (cx_q == CX_LAST) begin
        cx_q <= '0;
        cy_q <= cy_q + CYW'(1);
      end else begin
        cx_q <= cx_q + CXW'(1);
      end
    end
  end

  // Pixel address, corner mask, optional clip and colour for the current raster point
  always_comb begin
    x_wide_c    = {1'b0, bx_q} + 9'(cx_q);
    y_wide_c    = {1'b0, by_q} + 8'(cy_q);
    on_screen_c = (x_wide_c < 9'(SCREEN_W)) && (y_wide_c < 8'(SCREEN_H));
    corner_c    = ((cx_q == '0) || (cx_q == CX_LAST)) &&
                  ((cy_q == '0) || (cy_q == CY_LAST));
    // hook (2) and erase (3) are solid; gold and stone have transparent corners
    masked_c    = corner_c && !obj_q[1];
    pix_plot_c  = draw_c && !masked_c && (!CLIP_EN || on_screen_c);
    case (obj_q)
      2'd0:    pix_colour_c = COL_GOLD;
      2'd1:    pix_colour_c = COL_STONE;
      2'd2:    pix_colour_c = COL_HOOK;
      default: pix_colour_c = COL_ERASE;
    endcase
  end

  // Pixel stage register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      p_valid_q  <= 1'b0;
      p_plot_q   <= 1'b0;
      p_done_q   <= 1'b0;
      p_x_q      <= 8'd0;
      p_y_q      <= 7'd0;
      p_colour_q <= 3'd0;
    end else begin
      p_valid_q  <= draw_c;
      p_plot_q   <= pix_plot_c;
      p_done_q   <= fin_c;
      p_x_q      <= x_wide_c[7:0];
      p_y_q      <= y_wide_c[6:0];
      p_colour_q <= pix_colour_c;
    end
  end

  // Output registers; address and colour hold their last drawn value between draws
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      plot       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= p_plot_q;
      done <= p_done_q;
      if (p_valid_q) begin
        vga_x      <= p_x_q;
        vga_y      <= p_y_q;
        vga_colour <= p_colour_q;
      end
    end
  end

  // Busy spans accept through the done pulse; a same-edge re-accept keeps it high
  always_ff @(posedge clk) begin
    if (!resetn)       busy <= 1'b0;
    else if (accept_c) busy <= 1'b1;
    else if (done)     busy <= 1'b0;
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter (8x8 sprite, 160x120 screen).
// Edge numbering is relative to the accepting edge (edge 0).

module tb_sprite_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic [1:0] obj_type;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // results collected by run_draw
  int n_plot, corner_hit, colour_bad, offscreen;
  int done_cnt, first_done, last_done;
  int first_plot, last_plot, late_plot;
  int last_x, last_y;
  logic busy_e0, busy_e66, busy_e67;

  sprite_plotter dut (
    .clk(clk), .resetn(resetn), .enable(enable), .obj_type(obj_type),
    .base_x(base_x), .base_y(base_y), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and record what comes out for n_edges edges after accept.
  // drop_at: edge after which enable falls early (0 = never).
  // raise_at: edge after which enable is raised again (0 = never).
  // hold: keep enable high after done.
  task automatic run_draw(input logic [1:0] t, input int bx, input int by,
                          input int drop_at, input int raise_at, input bit hold,
                          input int n_edges);
    logic [2:0] exp_col;
    int cx0, cx1, cy0, cy1;
    case (t)
      2'd0:    exp_col = 3'b110;
      2'd1:    exp_col = 3'b111;
      2'd2:    exp_col = 3'b000;
      default: exp_col = 3'b011;
    endcase
    cx0 = bx % 256; cx1 = (bx + 7) % 256;
    cy0 = by % 128; cy1 = (by + 7) % 128;
    n_plot = 0; corner_hit = 0; colour_bad = 0; offscreen = 0;
    done_cnt = 0; first_done = 0; last_done = 0;
    first_plot = 0; last_plot = 0; late_plot = 0;
    last_x = -1; last_y = -1;
    busy_e66 = 1'bx; busy_e67 = 1'bx;
    obj_type = t;
    base_x   = 8'(bx);
    base_y   = 7'(by);
    enable   = 1'b1;
    tick();
    busy_e0 = busy;
    for (int e = 1; e <= n_edges; e++) begin
      tick();
      if (e == 66) busy_e66 = busy;
      if (e == 67) busy_e67 = busy;
      if (plot === 1'b1) begin
        if (e <= 65) begin
          n_plot++;
          if (first_plot == 0) first_plot = e;
          last_plot = e;
          last_x = int'(vga_x);
          last_y = int'(vga_y);
          if (vga_colour !== exp_col) colour_bad++;
          if (int'(vga_x) >= 160) offscreen++;
          if (t < 2'd2 &&
              (int'(vga_x) == cx0 || int'(vga_x) == cx1) &&
              (int'(vga_y) == cy0 || int'(vga_y) == cy1))
            corner_hit++;
        end else if (late_plot == 0) begin
          late_plot = e;
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = e;
        last_done = e;
        if (!hold && (raise_at == 0 || e > raise_at + 2)) enable = 1'b0;
      end
      if (drop_at != 0 && e == drop_at) enable = 1'b0;
      if (raise_at != 0 && e == raise_at) enable = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; obj_type = 2'd0; base_x = 8'd0; base_y = 7'd0;
    repeat (3) tick();
    checks++; if (vga_x !== 8'd0)      begin errors++; $display("FAIL reset_vga_x got %0d want 0", vga_x); end
    checks++; if (vga_y !== 7'd0)      begin errors++; $display("FAIL reset_vga_y got %0d want 0", vga_y); end
    checks++; if (vga_colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %b want 000", vga_colour); end
    checks++; if (plot !== 1'b0)       begin errors++; $display("FAIL reset_plot got %b want 0", plot); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_gold();
    run_draw(2'd0, 10, 20, 0, 0, 1'b0, 72);
    checks++; if (n_plot !== 60)     begin errors++; $display("FAIL gold_plots got %0d want 60", n_plot); end
    checks++; if (corner_hit !== 0)  begin errors++; $display("FAIL gold_corners got %0d want 0", corner_hit); end
    checks++; if (colour_bad !== 0)  begin errors++; $display("FAIL gold_colour got %0d bad want 0", colour_bad); end
    checks++; if (done_cnt !== 1)    begin errors++; $display("FAIL gold_done_count got %0d want 1", done_cnt); end
    checks++; if (first_done !== 66) begin errors++; $display("FAIL gold_done_edge got %0d want 66", first_done); end
    checks++; if (first_plot !== 3)  begin errors++; $display("FAIL gold_first_plot got %0d want 3", first_plot); end
    checks++; if (last_plot !== 64)  begin errors++; $display("FAIL gold_last_plot got %0d want 64", last_plot); end
    checks++; if (late_plot !== 0)   begin errors++; $display("FAIL gold_extra_plot got %0d want 0", late_plot); end
    checks++; if (busy_e0 !== 1'b1)  begin errors++; $display("FAIL gold_busy_rise got %b want 1", busy_e0); end
    checks++; if (busy_e66 !== 1'b1) begin errors++; $display("FAIL gold_busy_at_done got %b want 1", busy_e66); end
    checks++; if (busy_e67 !== 1'b0) begin errors++; $display("FAIL gold_busy_fall got %b want 0", busy_e67); end
  endtask

  task automatic test_reset_mid_draw();
    int n2;
    obj_type = 2'd0; base_x = 8'd10; base_y = 7'd20; enable = 1'b1;
    tick();
    for (int e = 1; e <= 29; e++) tick();
    resetn = 1'b0;
    tick();
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL midrst_plot got %b want 0", plot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    resetn = 1'b1; enable = 1'b0;
    tick();
    n2 = 0;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (plot === 1'b1 || busy === 1'b1) n2++;
    end
    checks++; if (n2 !== 0) begin errors++; $display("FAIL midrst_idle_activity got %0d want 0", n2); end
    run_draw(2'd0, 10, 20, 0, 0, 1'b0, 70);
    checks++; if (n_plot !== 60)     begin errors++; $display("FAIL midrst_redraw_plots got %0d want 60", n_plot); end
    checks++; if (first_done !== 66) begin errors++; $display("FAIL midrst_redraw_done got %0d want 66", first_done); end
  endtask

  task automatic test_held_enable();
    int extra_plot, extra_done, extra_busy;
    run_draw(2'd1, 30, 40, 0, 0, 1'b1, 70);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL held_first_done got %0d want 1", done_cnt); end
    extra_plot = 0; extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (plot === 1'b1) extra_plot++;
      if (done === 1'b1) extra_done++;
      if (busy === 1'b1) extra_busy++;
    end
    checks++; if (extra_plot !== 0) begin errors++; $display("FAIL held_no_redraw_plot got %0d want 0", extra_plot); end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL held_no_redraw_done got %0d want 0", extra_done); end
    checks++; if (extra_busy !== 0) begin errors++; $display("FAIL held_busy got %0d want 0", extra_busy); end
    enable = 1'b0;
    tick();
    run_draw(2'd1, 30, 40, 0, 0, 1'b0, 70);
    checks++; if (n_plot !== 60)     begin errors++; $display("FAIL held_redraw_plots got %0d want 60", n_plot); end
    checks++; if (first_done !== 66) begin errors++; $display("FAIL held_redraw_done got %0d want 66", first_done); end
  endtask

  task automatic test_erase();
    run_draw(2'd3, 0, 0, 0, 0, 1'b0, 70);
    checks++; if (n_plot !== 64)    begin errors++; $display("FAIL erase_plots got %0d want 64", n_plot); end
    checks++; if (colour_bad !== 0) begin errors++; $display("FAIL erase_colour got %0d bad want 0", colour_bad); end
    checks++; if (last_x !== 7 || last_y !== 7)
      begin errors++; $display("FAIL erase_last_pixel got (%0d,%0d) want (7,7)", last_x, last_y); end
    checks++; if (vga_colour !== 3'b011) begin errors++; $display("FAIL erase_colour_hold got %b want 011", vga_colour); end
  endtask

  task automatic test_clip();
    int exp_n, exp_off;
`ifdef PLOTTER_CLIP_EN
    exp_n = 15; exp_off = 0;
`else
    exp_n = 60; exp_off = 30;
`endif
    run_draw(2'd1, 156, 116, 0, 0, 1'b0, 70);
    checks++; if (n_plot !== exp_n)     begin errors++; $display("FAIL clip_plots got %0d want %0d", n_plot, exp_n); end
    checks++; if (offscreen !== exp_off) begin errors++; $display("FAIL clip_offscreen got %0d want %0d", offscreen, exp_off); end
    checks++; if (corner_hit !== 0)     begin errors++; $display("FAIL clip_corners got %0d want 0", corner_hit); end
    checks++; if (first_done !== 66)    begin errors++; $display("FAIL clip_done_edge got %0d want 66", first_done); end
  endtask

  task automatic test_back_to_back();
    // enable falls after 5 DRAW cycles, returns right after edge 65
    run_draw(2'd2, 50, 0, 5, 65, 1'b0, 140);
    checks++; if (n_plot !== 64)     begin errors++; $display("FAIL early_drop_plots got %0d want 64", n_plot); end
    checks++; if (colour_bad !== 0)  begin errors++; $display("FAIL early_drop_colour got %0d bad want 0", colour_bad); end
    checks++; if (first_done !== 66) begin errors++; $display("FAIL early_drop_done got %0d want 66", first_done); end
    checks++; if (late_plot !== 69)  begin errors++; $display("FAIL b2b_second_start got %0d want 69", late_plot); end
    checks++; if (done_cnt !== 2)    begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
    checks++; if (last_done !== 133) begin errors++; $display("FAIL b2b_second_done got %0d want 133", last_done); end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; obj_type = 2'd0; base_x = 8'd0; base_y = 7'd0;
    test_reset();
    test_gold();
    test_reset_mid_draw();
    test_held_enable();
    test_erase();
    test_clip();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
